// File: rtl/cpu_mc_seq.sv
// Multi-cycle RV32I sequencer: FETCH/EXEC/MEM/WB over req/ack memories.
// Owns PC, IR, ALU-result, memory-data, target and immediate registers, plus the writeback mux.
module cpu_mc_seq #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     MAX_WAIT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     dec_instr_o,
    input  logic            dec_is_load_i,
    input  logic            dec_is_store_i,
    input  logic            dec_reg_we_i,
    input  logic [2:0]      dec_wb_sel_i,
    input  logic [1:0]      dec_pc_sel_i,
    input  logic [XLEN-1:0] dec_imm_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] tgt_pc_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            rf_we_o,
    output logic [XLEN-1:0] rf_wd_o,
    output logic [XLEN-1:0] pc_o,
    output logic            retire_o,
    output logic [31:0]     instr_cnt_o,
    output logic            err_o
);

    localparam int unsigned      WaitW    = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {StBoot, StFetch, StExec, StMem, StWb, StHalt} state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q, alur_q, mdr_q, tgt_q, imm_q;
    logic [31:0]       ir_q, cnt_q;
    logic              err_q;
    logic [WaitW-1:0]  wait_q;

    logic [XLEN-1:0]   pc_plus4, next_pc;
    logic              pc_misaligned, wb_ok;

    always_comb begin
        pc_plus4 = pc_q + XLEN'(4);
        next_pc  = pc_plus4;
        case (dec_pc_sel_i)
            2'b01:   next_pc = tgt_q;
            2'b10:   next_pc = {alur_q[XLEN-1:1], 1'b0};
            default: next_pc = pc_plus4;
        endcase
        pc_misaligned = |next_pc[1:0];

        case (dec_wb_sel_i)
            3'b001:  rf_wd_o = mdr_q;
            3'b010:  rf_wd_o = pc_plus4;
            3'b011:  rf_wd_o = imm_q;
            3'b100:  rf_wd_o = tgt_q;
            default: rf_wd_o = alur_q;
        endcase
    end

    // A misaligned next PC suppresses the whole writeback, not just the PC update.
    assign wb_ok       = (state_q == StWb) && !pc_misaligned;
    assign retire_o    = wb_ok;
    assign rf_we_o     = wb_ok && dec_reg_we_i;
    assign imem_req_o  = (state_q == StFetch);
    assign imem_addr_o = pc_q;
    assign dmem_req_o  = (state_q == StMem);
    assign dmem_we_o   = (state_q == StMem) && dec_is_store_i;
    assign dmem_addr_o = alur_q;
    assign dec_instr_o = ir_q;
    assign pc_o        = pc_q;
    assign instr_cnt_o = cnt_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0013;
            alur_q  <= '0;
            mdr_q   <= '0;
            tgt_q   <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    wait_q  <= '0;
                    state_q <= StFetch;
                end
                StFetch: begin
                    if (imem_ack_i) begin
                        ir_q    <= imem_rdata_i;
                        state_q <= StExec;
                    end else if (wait_q == WaitLast) begin
                        err_q   <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StExec: begin
                    alur_q  <= alu_out_i;
                    imm_q   <= dec_imm_i;
                    tgt_q   <= tgt_pc_i;
                    wait_q  <= '0;
                    state_q <= (dec_is_load_i || dec_is_store_i) ? StMem : StWb;
                end
                StMem: begin
                    if (dmem_ack_i) begin
                        if (!dec_is_store_i) mdr_q <= dmem_rdata_i;
                        state_q <= StWb;
                    end else if (wait_q == WaitLast) begin
                        err_q   <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StWb: begin
                    wait_q <= '0;
                    if (pc_misaligned) begin
                        err_q   <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        pc_q    <= next_pc;
                        cnt_q   <= cnt_q + 32'd1;
                        state_q <= StFetch;
                    end
                end
                StHalt: state_q <= StHalt;
                default: state_q <= StHalt;
            endcase
        end
    end

endmodule
